// File: rtl/prio_update_pkg.sv
// prio_update_pkg: mode encodings and freeze FSM state shared by the update bank
package prio_update_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_OR   = 2'b11;
  typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/prio_update_chan.sv
// prio_update_chan: one channel register with sticky accumulate overflow and clear > freeze > load > mode priority
module prio_update_chan
  import prio_update_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             frozen,
  output logic [WIDTH-1:0] q,
  output logic             ovf
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;
  logic             ovf_set;
  always_comb begin
    sum     = {1'b0, q} + {1'b0, in};
    nxt     = load ? in : !en ? q : mode == MODE_LOAD ? in : mode == MODE_ACC ? sum[WIDTH-1:0] : mode == MODE_OR ? (q | in) : q;
    ovf_set = !load && en && mode == MODE_ACC && sum[WIDTH];
  end
  // clear is deliberately ahead of the freeze so software can scrub a channel mid-window
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (!frozen) begin
      q   <= nxt;
      ovf <= ovf | ovf_set;
    end
  end
endmodule

// File: rtl/prio_update_bank.sv
// prio_update_bank: NCH prioritised update channels plus a global freeze window FSM
module prio_update_bank
  import prio_update_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int HOLD_CYC = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [NCH-1:0]       CLR,
  input  logic [NCH-1:0]       LOAD,
  input  logic [2*NCH-1:0]     MODE,
  input  logic [NCH*WIDTH-1:0] IN,
  input  logic                 ARM,
  output logic [NCH*WIDTH-1:0] OUT,
  output logic [NCH-1:0]       OVF,
  output logic                 BUSY,
  output logic                 DONE
);
  localparam int CW = $clog2(HOLD_CYC + 1);
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("prio_update_bank: HOLD_CYC must be at least 1");
  end
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          done_nxt;
  // ARM while frozen is dropped; cnt counts the remaining HOLD cycles down to zero
  always_comb begin
    state_nxt = state == IDLE ? (ARM ? HOLD : IDLE) : (cnt == '0 ? IDLE : HOLD);
    cnt_nxt   = state == IDLE ? (ARM ? CW'(HOLD_CYC - 1) : cnt) : (cnt == '0 ? cnt : cnt - CW'(1));
    done_nxt  = state == HOLD && cnt == '0;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      DONE  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      DONE  <= done_nxt;
    end
  end
  assign BUSY = state == HOLD;
  genvar i;
  for (i = 0; i < NCH; i++) begin : g_ch
    prio_update_chan #(.WIDTH(WIDTH)) u_ch (
      .clk   (CLK),
      .rst   (RST),
      .clr   (CLR[i]),
      .load  (LOAD[i]),
      .en    (EN),
      .mode  (MODE[2*i +: 2]),
      .in    (IN[WIDTH*i +: WIDTH]),
      .frozen(BUSY),
      .q     (OUT[WIDTH*i +: WIDTH]),
      .ovf   (OVF[i])
    );
  end
endmodule

// File: tb/tb_prio_update_bank.sv
// tb_prio_update_bank: vector table, freeze/reset sequences and random run against a behavioural model
module tb_prio_update_bank;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int HC = 4;
  logic clk = 1'b0;
  logic rst, en, arm;
  logic [N-1:0] clr, load, ovf;
  logic [2*N-1:0] mode;
  logic [N*W-1:0] din, q;
  logic busy, done;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] m_out [N];
  logic [N-1:0] m_ovf;
  int left;
  logic m_done;
  typedef struct {
    logic rst, en, arm;
    logic [3:0] clr, load;
    logic [7:0] mode;
    logic [31:0] din, eout;
    logic [3:0] eovf;
    logic ebusy, edone;
  } vec_t;
  vec_t vt [13];
  prio_update_bank #(.WIDTH(W), .NCH(N), .HOLD_CYC(HC)) dut (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr), .LOAD(load), .MODE(mode),
    .IN(din), .ARM(arm), .OUT(q), .OVF(ovf), .BUSY(busy), .DONE(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // freeze modelled as a count of remaining busy cycles rather than a state machine
  task automatic model_step();
    int s;
    logic [W-1:0] x;
    bit frz;
    if (rst) begin
      for (int c = 0; c < N; c++) m_out[c] = '0;
      m_ovf = '0;
      left = 0;
      m_done = 1'b0;
      return;
    end
    frz = left > 0;
    for (int c = 0; c < N; c++) begin
      x = din[W*c +: W];
      if (clr[c]) begin
        m_out[c] = '0;
        m_ovf[c] = 1'b0;
      end else if (!frz) begin
        if (load[c]) m_out[c] = x;
        else if (en) begin
          case (mode[2*c +: 2])
            2'd1: m_out[c] = x;
            2'd2: begin
              s = int'(m_out[c]) + int'(x);
              if (s >= (1 << W)) m_ovf[c] = 1'b1;
              m_out[c] = W'(s % (1 << W));
            end
            2'd3: m_out[c] = m_out[c] | x;
            default: ;
          endcase
        end
      end
    end
    m_done = left == 1;
    if (left > 0) left--;
    else if (arm) left = HC;
  endtask
  function automatic logic [31:0] m_pack();
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < N; c++) r[W*c +: W] = m_out[c];
    return r;
  endfunction
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("mdl_out", q, m_pack());
    chk("mdl_ovf", {28'd0, ovf}, {28'd0, m_ovf});
    chk("mdl_busy", {31'd0, busy}, {31'd0, left > 0});
    chk("mdl_done", {31'd0, done}, {31'd0, m_done});
  endtask
  initial begin
    logic eb [7];
    logic ed [7];
    logic [31:0] eo;
    int nb, nd;
    vt[0]  = '{1'b1, 1'b1, 1'b1, 4'hA, 4'h5, 8'hE4, 32'hDEADBEEF, 32'h00000000, 4'h0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b1, 4'h5, 4'hA, 8'h1B, 32'h12345678, 32'h00000000, 4'h0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h1, 8'h00, 32'h0000005A, 32'h0000005A, 4'h0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b0, 4'h2, 4'h2, 8'h04, 32'h0000FF00, 32'h0000005A, 4'h0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h2, 8'h04, 32'h0000FF00, 32'h0000FF5A, 4'h0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h4, 8'h00, 32'h00F00000, 32'h00F0FF5A, 4'h0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h20, 32'h00200000, 32'h0010FF5A, 4'h4, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h20, 32'h00010000, 32'h0011FF5A, 4'h4, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 1'b0, 4'h4, 4'h0, 8'h20, 32'h00010000, 32'h0000FF5A, 4'h0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h8, 8'h00, 32'h0F000000, 32'h0F00FF5A, 4'h0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'hC0, 32'hA0000000, 32'hAF00FF5A, 4'h0, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'hC0, 32'hA0000000, 32'hAF00FF5A, 4'h0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 8'h02, 32'h00000010, 32'hAF00FF6A, 4'h0, 1'b0, 1'b0};
    for (int k = 0; k < 13; k++) begin
      rst = vt[k].rst; en = vt[k].en; arm = vt[k].arm; clr = vt[k].clr;
      load = vt[k].load; mode = vt[k].mode; din = vt[k].din;
      cyc();
      chk($sformatf("vec%0d_out", k), q, vt[k].eout);
      chk($sformatf("vec%0d_ovf", k), {28'd0, ovf}, {28'd0, vt[k].eovf});
      chk($sformatf("vec%0d_busy", k), {31'd0, busy}, {31'd0, vt[k].ebusy});
      chk($sformatf("vec%0d_done", k), {31'd0, done}, {31'd0, vt[k].edone});
    end
    eb = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    nb = 0;
    nd = 0;
    eo = 32'hAF00FF11;
    en = 1'b0;
    mode = '0;
    for (int c = 0; c < 7; c++) begin
      arm = c == 0 || c == 3;
      clr = c == 2 ? 4'h1 : 4'h0;
      load = c == 0 ? 4'h1 : 4'hF;
      din = c == 0 ? 32'h00000011 : $urandom();
      if (c == 2) eo = 32'hAF00FF00;
      if (c >= 5) eo = din;
      cyc();
      nb += int'(busy);
      nd += int'(done);
      chk($sformatf("frz%0d_out", c), q, eo);
      chk($sformatf("frz%0d_busy", c), {31'd0, busy}, {31'd0, eb[c]});
      chk($sformatf("frz%0d_done", c), {31'd0, done}, {31'd0, ed[c]});
    end
    chk("frz_busy_cycles", nb, 32'd4);
    chk("frz_done_pulses", nd, 32'd1);
    clr = '0; load = '0; arm = 1'b1;
    cyc();
    chk("rstfrz_busy", {31'd0, busy}, 32'd1);
    arm = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rstfrz_busy0", {31'd0, busy}, 32'd0);
    chk("rstfrz_out0", q, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      chk($sformatf("rstfrz_nodone%0d", c), {31'd0, done}, 32'd0);
    end
    for (int k = 0; k < 400; k++) begin
      rst  = $urandom_range(39) == 0;
      en   = 1'($urandom());
      clr  = 4'($urandom()) & 4'($urandom()) & 4'($urandom());
      load = 4'($urandom()) & 4'($urandom());
      mode = 8'($urandom());
      din  = $urandom();
      arm  = $urandom_range(7) == 0;
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prio_update_bank.md
Name: prio_update_bank

Overview:
- Parametrised multi-channel successor to the single-bit prioritised update register.
- NCH independent WIDTH-bit channel registers, each updated through a fixed priority chain: clear, load, then a per-channel mode case.
- A global freeze FSM holds all channels for a programmable window on request.
- Used as a status/capture register bank; also the metrics-tool regression target for deep nested-if/case structures.

Parameters:
- WIDTH, 8, bits per channel register (≥1).
- NCH, 4, number of channels (≥1).
- HOLD_CYC, 4, freeze-window length in cycles (≥1; 0 is illegal, flagged by an elaboration check).

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- EN  input  1  global enable for the mode-case path.
- CLR  input  NCH  per-channel clear.
- LOAD  input  NCH  per-channel direct load.
- MODE  input  2*NCH  per-channel mode; channel i uses MODE[2i+1:2i].
- IN  input  NCH*WIDTH  per-channel data; channel i uses IN[WIDTH*i +: WIDTH].
- ARM  input  1  freeze request.
- OUT  output  NCH*WIDTH  channel registers, packed like IN.
- OVF  output  NCH  per-channel sticky accumulate overflow.
- BUSY  output  1  high while frozen.
- DONE  output  1  one-cycle pulse at the end of the freeze.

Behaviour:
- Reset: synchronous, active-high. At RST=1 on an edge: OUT=0, OVF=0, BUSY=0, DONE=0, FSM=IDLE, counter=0. RST overrides every other input.
- Channel update priority, evaluated per channel per edge, first match wins:
  1. RST: OUT[i]=0, OVF[i]=0.
  2. CLR[i]: OUT[i]=0, OVF[i]=0. Clear is honoured even while frozen.
  3. FSM==HOLD: OUT[i] and OVF[i] unchanged.
  4. LOAD[i]: OUT[i]=IN[i]. OVF[i] unchanged.
  5. EN=1, mode case:
     - 00: hold.
     - 01: OUT[i]=IN[i].
     - 10: OUT[i]=OUT[i]+IN[i], mod 2^WIDTH (wrap). If the carry out is set, OVF[i]=1 (sticky).
     - 11: OUT[i]=OUT[i] | IN[i].
  6. Otherwise hold.
- All outputs are registered. An update is visible on OUT one cycle after the edge that samples the inputs.
- Channels are fully independent. Simultaneous CLR/LOAD/EN on different channels all take effect in the same cycle.
- FSM states: IDLE, HOLD.
  - IDLE, ARM=1: go to HOLD, cnt=HOLD_CYC-1, BUSY=1 from the next cycle. Channel updates in the ARM cycle still occur, because the FSM is still IDLE when they are evaluated.
  - HOLD, cnt≠0: cnt decrements.
  - HOLD, cnt==0: go to IDLE, BUSY=0, DONE=1 for exactly one cycle.
  - BUSY is therefore high for exactly HOLD_CYC cycles.
  - ARM in HOLD is ignored (no extension, no queueing).
  - ARM in the cycle that DONE is asserted (FSM already IDLE) starts a new freeze.
- Reset mid-freeze: RST aborts to IDLE, BUSY=0, and DONE is not pulsed.
- Counter width: $clog2(HOLD_CYC+1); it must not wrap.

Decomposition:
- Shared package prio_update_pkg:
  - mode encodings MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_ACC=2'b10, MODE_OR=2'b11;
  - FSM state typedef (IDLE, HOLD).
- Sub-module prio_update_chan: one channel register plus OVF and its priority chain. Inputs are clr, load, en, mode, in, and frozen. Instantiated NCH times by a generate loop.
- The top level holds the FSM, counter, BUSY and DONE only.

Test Plan (WIDTH=8, NCH=4, HOLD_CYC=4):
1. RST=1 for 2 cycles with all inputs toggling -> OUT=0, OVF=0, BUSY=0, DONE=0. Release, then LOAD=4'b0001, IN ch0=8'h5A -> next cycle OUT ch0=8'h5A, other channels stay 0.
2. Priority: ch1 with CLR=1, LOAD=1, EN=1, MODE=01, IN=8'hFF -> OUT ch1=0. Drop CLR -> OUT ch1=8'hFF (LOAD wins over the mode case).
3. Accumulate: ch2=8'hF0, MODE=10, EN=1, IN=8'h20 -> OUT=8'h10, OVF[2]=1. Next add of IN=8'h01 -> OUT=8'h11, OVF[2] stays 1. CLR[2] -> OUT=0, OVF[2]=0.
4. OR mode: ch3=8'h0F, MODE=11, IN=8'hA0 -> OUT=8'hAF. EN=0 -> held at 8'hAF.
5. Freeze: pulse ARM, then drive LOAD=4'hF with new IN for 6 cycles.
   - BUSY high for exactly 4 cycles; OUT unchanged during BUSY.
   - DONE single pulse after the 4th cycle; LOAD takes effect the cycle after.
   - CLR[0] issued during BUSY clears ch0.
   - A second ARM mid-freeze does not extend it.
6. RST asserted in the 2nd HOLD cycle -> next cycle BUSY=0, OUT=0, and no DONE pulse in any following cycle.
